// File: rtl/fc3_ctrl_pkg.sv
// rtl/fc3_ctrl_pkg.sv - shared constants and state encoding for the fc layer controllers
//
// Holds the one-hot controller state encoding, default layer dimensions and
// delays, and the address widths of the feature, weight and output buffers.
// Other fc ctrl blocks import this package so they all use the same values.
package fc3_ctrl_pkg;

    localparam int N_IN_DEF    = 84;
    localparam int N_OUT_DEF   = 10;
    localparam int WR_DLY_DEF  = 6;
    localparam int CLR_DLY_DEF = 3;

    localparam int F7_AW = 7;
    localparam int W7_AW = 10;
    localparam int F8_AW = 4;
    localparam int B7_AW = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } fc_state_e;

endpackage

// File: rtl/fc3_ctrl_pulse_dly.sv
// rtl/fc3_ctrl_pulse_dly.sv - fixed-depth shift register used for every strobe delay chain
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears every stage
//   d    - WIDTH-bit value entering the chain
//   q    - d delayed by DEPTH clock cycles (DEPTH >= 1)
module pulse_dly #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fc3_ctrl.sv
// rtl/fc3_ctrl.sv - address sequencer and strobe generator for the final fully-connected layer
//
// Walks N_IN inputs for each of N_OUT neurons, issuing feature and weight
// read addresses once per RUN cycle, and produces the delayed accumulator
// clear, output write and layer-done strobes that line up with the MAC pipe.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   fc3_start - start pulse, only honoured in IDLE
//   f7_raddr  - feature buffer read address (input index)
//   w7_raddr  - weight ROM read address (neuron*N_IN + input)
//   f8_wr_en  - one-cycle write strobe per finished neuron
//   f8_waddr  - output buffer write address, valid with f8_wr_en
//   fc3_clr   - accumulator clear, one pulse per neuron
//   fc3_done  - one-cycle layer-complete pulse
//   b7_raddr  - bias ROM read address (only with FC3_BIAS_ADDR_EN defined)
//
// Build option: define FC3_BIAS_ADDR_EN to add the b7_raddr output;
// otherwise bias is supplied externally and the port does not exist.
module fc3_ctrl
    import fc3_ctrl_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int WR_DLY  = WR_DLY_DEF,
    parameter int CLR_DLY = CLR_DLY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fc3_start,
    output logic [F7_AW-1:0] f7_raddr,
    output logic [W7_AW-1:0] w7_raddr,
    output logic             f8_wr_en,
    output logic [F8_AW-1:0] f8_waddr,
    output logic             fc3_clr,
`ifdef FC3_BIAS_ADDR_EN
    output logic [B7_AW-1:0] b7_raddr,
`endif
    output logic             fc3_done
);

    localparam logic [F7_AW-1:0] IN_LAST  = F7_AW'(N_IN - 1);
    localparam logic [F8_AW-1:0] OUT_LAST = F8_AW'(N_OUT - 1);

    fc_state_e        state;
    fc_state_e        state_nxt;
    logic             run;
    logic             done_ev;
    logic             last_issue;
    logic             wr_ev;
    logic             clr_ev;
    logic [F7_AW-1:0] cnt_in;
    logic [F8_AW-1:0] cnt_out;
    logic [W7_AW-1:0] w7_cnt;

    assign last_issue = run && (cnt_in == IN_LAST) && (cnt_out == OUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; fc3_start outside IDLE is simply not looked at
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fc3_start) state_nxt = ST_RUN;
            ST_RUN:  if (last_issue) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        run     = 1'b0;
        done_ev = 1'b0;
        case (state)
            ST_RUN:  run = 1'b1;
            ST_DONE: done_ev = 1'b1;
            default: ;
        endcase
    end

    // Counters sit at zero outside RUN and are cleared on the last issue so
    // DONE and IDLE both present address 0.  w7_cnt runs independently of the
    // loop counters so no neuron*N_IN product is ever formed.
    always_ff @(posedge clk) begin
        if (rst || !run || last_issue) begin
            cnt_in  <= '0;
            cnt_out <= '0;
            w7_cnt  <= '0;
        end else begin
            w7_cnt <= w7_cnt + 1'b1;
            if (cnt_in == IN_LAST) begin
                cnt_in  <= '0;
                cnt_out <= cnt_out + 1'b1;
            end else begin
                cnt_in <= cnt_in + 1'b1;
            end
        end
    end

    assign f7_raddr = cnt_in;
    assign w7_raddr = w7_cnt;

    assign wr_ev  = run && (cnt_in == IN_LAST);
    assign clr_ev = run && (cnt_in == '0);

    // Write strobe, its address and the done strobe travel together.  DONE is
    // entered the cycle after the final write event, so sharing the chain
    // keeps fc3_done exactly one cycle behind the last f8_wr_en.  The address
    // is zeroed between strobes so f8_waddr idles at 0.
    logic [F8_AW+1:0] wr_chain_d;
    logic [F8_AW+1:0] wr_chain_q;

    assign wr_chain_d = {done_ev, wr_ev, (wr_ev ? cnt_out : {F8_AW{1'b0}})};

    pulse_dly #(
        .DEPTH (WR_DLY + 1),
        .WIDTH (F8_AW + 2)
    ) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d   (wr_chain_d),
        .q   (wr_chain_q)
    );

    assign fc3_done = wr_chain_q[F8_AW+1];
    assign f8_wr_en = wr_chain_q[F8_AW];
    assign f8_waddr = wr_chain_q[F8_AW-1:0];

    pulse_dly #(
        .DEPTH (CLR_DLY),
        .WIDTH (1)
    ) u_clr_dly (
        .clk (clk),
        .rst (rst),
        .d   (clr_ev),
        .q   (fc3_clr)
    );

`ifdef FC3_BIAS_ADDR_EN
    // cnt_out is first registered as the neuron index of the issued address,
    // then runs WR_DLY-1 further stages so the bias address is presented one
    // cycle before the matching f8_wr_en, in step with the bias-add stage.
    logic [B7_AW-1:0] nidx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            nidx_q <= '0;
        end else begin
            nidx_q <= B7_AW'(cnt_out);
        end
    end

    pulse_dly #(
        .DEPTH (WR_DLY - 1),
        .WIDTH (B7_AW)
    ) u_b7_dly (
        .clk (clk),
        .rst (rst),
        .d   (nidx_q),
        .q   (b7_raddr)
    );
`endif

endmodule

// File: tb/tb_fc3_ctrl.sv
// tb/tb_fc3_ctrl.sv - self-checking bench for fc3_ctrl with a schedule-based reference model
module tb_fc3_ctrl;

    localparam int MAXC  = 8192;
    localparam int N_IN  = 84;
    localparam int N_OUT = 10;
    localparam int RUN_LEN = N_IN * N_OUT;

    logic       clk = 1'b0;
    logic       rst;
    logic       fc3_start;
    logic [6:0] f7_raddr;
    logic [9:0] w7_raddr;
    logic       f8_wr_en;
    logic [3:0] f8_waddr;
    logic       fc3_clr;
    logic       fc3_done;
`ifdef FC3_BIAS_ADDR_EN
    logic [3:0] b7_raddr;
    int         prev_b7;
`endif

    fc3_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .fc3_start (fc3_start),
        .f7_raddr  (f7_raddr),
        .w7_raddr  (w7_raddr),
        .f8_wr_en  (f8_wr_en),
        .f8_waddr  (f8_waddr),
        .fc3_clr   (fc3_clr),
`ifdef FC3_BIAS_ADDR_EN
        .b7_raddr  (b7_raddr),
`endif
        .fc3_done  (fc3_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected output per absolute cycle, default zero
    int exp_f7   [MAXC];
    int exp_w7   [MAXC];
    int exp_wr   [MAXC];
    int exp_wa   [MAXC];
    int exp_clr  [MAXC];
    int exp_done [MAXC];
    int idle_from = 0;

    // Tallies of observed DUT activity, reset per phase by the driver
    int cnt_wr, cnt_clr, cnt_done, first_wr, first_clr, done_cyc, last_waddr, max_w7;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic set(input int idx, input int which, input int val);
        if (idx < MAXC) begin
            case (which)
                0: exp_f7[idx]   = val;
                1: exp_w7[idx]   = val;
                2: exp_wr[idx]   = val;
                3: exp_wa[idx]   = val;
                4: exp_clr[idx]  = val;
                default: exp_done[idx] = val;
            endcase
        end
    endtask

    // A layer whose first RUN cycle is c0: addresses follow r, neuron k is
    // cleared at r=84k+3 and written at r=84k+90, done lands at r=847.
    task automatic fill_run(input int c0);
        for (int r = 0; r < RUN_LEN; r++) begin
            set(c0 + r, 0, r % N_IN);
            set(c0 + r, 1, r);
        end
        for (int k = 0; k < N_OUT; k++) begin
            set(c0 + N_IN * k + 3, 4, 1);
            set(c0 + N_IN * k + N_IN + 6, 2, 1);
            set(c0 + N_IN * k + N_IN + 6, 3, k);
        end
        set(c0 + RUN_LEN + 7, 5, 1);
    endtask

    task automatic reset_tallies();
        cnt_wr = 0; cnt_clr = 0; cnt_done = 0;
        first_wr = -1; first_clr = -1; done_cyc = -1;
        last_waddr = -1; max_w7 = 0;
    endtask

    // Compare process: outputs are checked at the falling edge, then the
    // model absorbs this cycle's inputs to schedule future outputs.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("f7_raddr", int'(f7_raddr), exp_f7[cyc]);
            chk("w7_raddr", int'(w7_raddr), exp_w7[cyc]);
            chk("f8_wr_en", int'(f8_wr_en), exp_wr[cyc]);
            chk("f8_waddr", int'(f8_waddr), exp_wa[cyc]);
            chk("fc3_clr",  int'(fc3_clr),  exp_clr[cyc]);
            chk("fc3_done", int'(fc3_done), exp_done[cyc]);
`ifdef FC3_BIAS_ADDR_EN
            if (f8_wr_en) chk("b7_raddr_lead", prev_b7, exp_wa[cyc]);
            prev_b7 = int'(b7_raddr);
`endif
            if (f8_wr_en) begin
                if (first_wr < 0) first_wr = cyc;
                cnt_wr++;
                last_waddr = int'(f8_waddr);
            end
            if (fc3_clr) begin
                if (first_clr < 0) first_clr = cyc;
                cnt_clr++;
            end
            if (fc3_done) begin
                cnt_done++;
                done_cyc = cyc;
            end
            if (int'(w7_raddr) > max_w7) max_w7 = int'(w7_raddr);

            if (rst) begin
                for (int i = cyc + 1; i < MAXC; i++) begin
                    exp_f7[i] = 0; exp_w7[i] = 0; exp_wr[i] = 0;
                    exp_wa[i] = 0; exp_clr[i] = 0; exp_done[i] = 0;
                end
                idle_from = cyc + 1;
            end else if (fc3_start && cyc >= idle_from) begin
                fill_run(cyc + 1);
                idle_from = cyc + 1 + RUN_LEN + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int s;

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_f7[i] = 0; exp_w7[i] = 0; exp_wr[i] = 0;
            exp_wa[i] = 0; exp_clr[i] = 0; exp_done[i] = 0;
        end
        reset_tallies();
        rst = 1'b1;
        fc3_start = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();

        // Single layer from a one-cycle start pulse
        reset_tallies();
        fc3_start = 1'b1;
        s = cyc;
        step();
        fc3_start = 1'b0;
        repeat (900) step();
        chk("p1_wr_count", cnt_wr, 10);
        chk("p1_clr_count", cnt_clr, 10);
        chk("p1_done_count", cnt_done, 1);
        chk("p1_first_wr_ofs", first_wr - s, 91);
        chk("p1_first_clr_ofs", first_clr - s, 4);
        chk("p1_done_ofs", done_cyc - s, 848);
        chk("p1_last_waddr", last_waddr, 9);
        chk("p1_max_w7", max_w7, 839);

        // Start held high: one layer, the next begins on the first IDLE cycle
        reset_tallies();
        fc3_start = 1'b1;
        s = cyc;
        repeat (843) step();
        fc3_start = 1'b0;
        repeat (1000) step();
        chk("p2_done_count", cnt_done, 2);
        chk("p2_wr_count", cnt_wr, 20);
        chk("p2_first_wr_ofs", first_wr - s, 91);
        chk("p2_done2_ofs", done_cyc - s, 842 + 848);

        // Reset during RUN cycle 200 aborts the layer
        reset_tallies();
        fc3_start = 1'b1;
        s = cyc;
        step();
        fc3_start = 1'b0;
        while (cyc < s + 201) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) step();
        chk("p3_wr_count", cnt_wr, 2);
        chk("p3_clr_count", cnt_clr, 3);
        chk("p3_done_count", cnt_done, 0);
        chk("p3_max_w7", max_w7, 200);

        // Fresh layer after the abort
        reset_tallies();
        fc3_start = 1'b1;
        s = cyc;
        step();
        fc3_start = 1'b0;
        repeat (900) step();
        chk("p4_wr_count", cnt_wr, 10);
        chk("p4_done_ofs", done_cyc - s, 848);
        chk("p4_last_waddr", last_waddr, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fc3_ctrl.md
FC3_CTRL -- requirements
Module: fc3_ctrl

Interface
REQ-001 Parameter N_IN, default 84: input features per output neuron (f7 length).
REQ-002 Parameter N_OUT, default 10: output neurons (f8 length, class scores).
REQ-003 Parameter WR_DLY, default 6: write-path delay (addr2data 2, mac 3, bias 1; no ReLU on final layer).
REQ-004 Parameter CLR_DLY, default 3: accumulator-clear delay (addr2data 2 + DSP 1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 fc3_start  in  1  start pulse; sampled only in IDLE.
REQ-008 f7_raddr  out  7  f7 feature buffer read address.
REQ-009 w7_raddr  out  10  weight ROM read address, neuron-major (neuron*N_IN + input).
REQ-010 f8_wr_en  out  1  one-cycle write strobe per finished neuron.
REQ-011 f8_waddr  out  4  f8 write address, valid with f8_wr_en.
REQ-012 fc3_clr  out  1  MAC accumulator clear, one pulse per neuron.
REQ-013 fc3_done  out  1  one-cycle layer-complete pulse.

Function
REQ-014 FSM SHALL be one-hot IDLE/RUN/DONE: IDLE->RUN on fc3_start; RUN->DONE when last input of last neuron is issued; DONE->IDLE unconditionally.
REQ-015 fc3_start in RUN or DONE SHALL be ignored; no restart, no queuing.
REQ-016 Inner counter cnt_in SHALL count 0..N_IN-1 every RUN cycle, wrapping to 0; outer counter cnt_out SHALL increment on each inner wrap, 0..N_OUT-1.
REQ-017 w7_raddr SHALL be a separate counter incremented every RUN cycle and cleared on layer end; no multiplier.
REQ-018 With r = RUN cycle index (0..N_IN*N_OUT-1): f7_raddr = r mod N_IN, w7_raddr = r.
REQ-019 In IDLE/DONE counters SHALL hold 0; addresses SHALL read 0.
REQ-020 Internal write event at r = N_IN*k + N_IN-1; f8_wr_en SHALL assert WR_DLY+1 cycles later with f8_waddr = k, delayed in the same shift chain.
REQ-021 Internal clear event at r = N_IN*k, gated by RUN; fc3_clr SHALL assert CLR_DLY cycles later.
REQ-022 fc3_done SHALL pulse WR_DLY+1 cycles after DONE entry, i.e. same cycle as final f8_wr_en +1.
REQ-023 Default run: exactly 840 RUN cycles, 10 f8_wr_en pulses, 10 fc3_clr pulses, 1 fc3_done pulse.
REQ-024 fc3_start asserted in the cycle DONE->IDLE is not yet sampled; the following IDLE cycle SHALL accept it; back-to-back layers SHALL not corrupt in-flight delayed strobes.

Reset
REQ-025 rst SHALL force IDLE, zero all counters, and clear every delay-chain stage, so all outputs are 0 the cycle after rst.
REQ-026 rst mid-RUN SHALL abort the layer: no later f8_wr_en, fc3_clr or fc3_done pulse from the aborted run.

Configuration
REQ-027 Macro FC3_BIAS_ADDR_EN: when defined, output b7_raddr (4 bits) = cnt_out delayed WR_DLY-1 cycles, aligned to the bias-add stage; when undefined, port and logic are absent and bias is supplied externally.

Structure
REQ-028 Shared package SHALL hold the state encodings, N_IN/N_OUT defaults and address widths for reuse across fc ctrl blocks.
REQ-029 One sub-module, pulse_dly (parameterised depth and width, sync-reset shift register), SHALL implement all delay chains.

Verification
REQ-030 rst, then fc3_start pulse -> f7_raddr 0..83 repeated 10x, w7_raddr 0..839 consecutively, RUN lasts 840 cycles.
REQ-031 Full run -> f8_wr_en at RUN-relative cycles 90, 174, ..., 846 with f8_waddr 0..9; fc3_clr at 3, 87, ..., 759; fc3_done at 847.
REQ-032 fc3_start held high throughout run -> single run only; second run begins the first IDLE cycle after DONE.
REQ-033 rst at RUN cycle 200 -> all outputs 0 next cycle; no f8_wr_en/fc3_done afterwards until new start.
REQ-034 With FC3_BIAS_ADDR_EN -> b7_raddr equals k one cycle before each f8_wr_en for waddr k.
